fp_special_case_pipe: RTL and testbench

// - Parametrised, pipelined special-case unit for the FP add/sub datapath; successor to the combinational single-precision selector.
// - Classifies both operands (NaN, Inf, zero, subnormal), decides if the IEEE-754 result bypasses the mantissa datapath and emits it.
// - Two register stages, valid/ready handshake, sticky exception flags and a saturating bypass counter.
// - Sits in parallel with the alignment/add stages; the final mux takes o_result when o_special=1.

---
 rtl/fp_special_case_pipe_if.sv | 39 +++
 rtl/fp_special_case_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_fp_special_case_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_special_case_pipe_if.sv
// Handshake/data bundle for fp_special_case_pipe.
// The slave modport is the view taken by the special-case unit itself;
// the master modport is the view of whoever feeds operands and drains results.
interface fp_special_case_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
);
  localparam int W = EXP_W + MAN_W + 1;

  // upstream side
  logic             i_valid;
  logic             o_ready;
  logic             i_op_sub;
  logic [W-1:0]     i_opa;
  logic [W-1:0]     i_opb;

  // downstream side
  logic             o_valid;
  logic             i_ready;
  logic             o_special;
  logic [1:0]       o_class;
  logic [W-1:0]     o_result;

  // status
  logic             o_flag_inv;
  logic             i_flag_clr;
  logic [CNT_W-1:0] o_bypass_cnt;

  modport slave (
    input  i_valid, i_op_sub, i_opa, i_opb, i_ready, i_flag_clr,
    output o_ready, o_valid, o_special, o_class, o_result, o_flag_inv, o_bypass_cnt
  );

  modport master (
    output i_valid, i_op_sub, i_opa, i_opb, i_ready, i_flag_clr,
    input  o_ready, o_valid, o_special, o_class, o_result, o_flag_inv, o_bypass_cnt
  );
endinterface

// File: rtl/fp_special_case_pipe.sv
// fp_special_case_pipe
// Two-stage special-case unit for the FP add/sub datapath. Stage 1 registers
// the operand classification (NaN / sNaN / Inf and, with flush-to-zero, zero),
// stage 2 registers the IEEE-754 bypass decision and result. Both stages use
// a valid/ready handshake with full throughput and hold data under stall.
// A sticky invalid flag and a saturating count of bypassed results are kept.
//
// Optional feature: define FP_PSC_FTZ_EN to treat subnormal operands as zero
// and to bypass the zero +/- zero case with a correctly signed zero. Without
// it, zero and subnormal operands always go through the mantissa datapath.
module fp_special_case_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  fp_special_case_pipe_if.slave bus
);

  localparam int W = EXP_W + MAN_W + 1;

  localparam logic [1:0] CLS_NORMAL = 2'b00;
  localparam logic [1:0] CLS_QNAN   = 2'b01;
  localparam logic [1:0] CLS_PINF   = 2'b10;
  localparam logic [1:0] CLS_NEG    = 2'b11;

  // Canonical quiet NaN: positive, all-ones exponent, only the quiet bit set.
  localparam logic [W-1:0]     QNAN_VAL = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Per-operand classification carried from stage 1 to stage 2. The sign of
  // operand b is already the effective sign (subtraction folded in).
  typedef struct packed {
    logic nan;
    logic snan;
    logic inf;
`ifdef FP_PSC_FTZ_EN
    logic zero;
`endif
    logic sign;
  } opcls_t;

  // Classify one operand from its sign, exponent and stored mantissa.
  function automatic opcls_t classify(input logic             sign,
                                      input logic [EXP_W-1:0] exp_f,
                                      input logic [MAN_W-1:0] man_f);
    opcls_t c;
    logic   e1;
    logic   mz;
    e1     = &exp_f;
    mz     = ~|man_f;
    c.sign = sign;
    c.nan  = e1 & ~mz;
    c.snan = e1 & ~mz & ~man_f[MAN_W-1];
    c.inf  = e1 & mz;
`ifdef FP_PSC_FTZ_EN
    // Zero or subnormal: both have an all-zero exponent field.
    c.zero = ~|exp_f;
`endif
    return c;
  endfunction

  // Signed infinity encoding.
  function automatic logic [W-1:0] inf_val(input logic sign);
    return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

`ifdef FP_PSC_FTZ_EN
  // Signed zero encoding.
  function automatic logic [W-1:0] zero_val(input logic sign);
    return {sign, {(W-1){1'b0}}};
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_r;
  opcls_t s1_a_r;
  opcls_t s1_b_r;

  logic             o_valid_r;
  logic             o_special_r;
  logic [1:0]       o_class_r;
  logic [W-1:0]     o_result_r;
  logic             s2_inv_r;
  logic             o_flag_inv_r;
  logic [CNT_W-1:0] o_bypass_cnt_r;

  logic s2_adv_s;
  logic o_ready_s;
  logic out_fire_s;
  logic byp_fire_s;

  assign s2_adv_s   = ~o_valid_r | bus.i_ready;
  assign o_ready_s  = ~s1_valid_r | s2_adv_s;
  assign out_fire_s = o_valid_r & bus.i_ready;
  assign byp_fire_s = out_fire_s & o_special_r;

  // ---------------------------------------------------------------------------
  // Stage 1: classification of both operands
  // ---------------------------------------------------------------------------
  opcls_t cls_a_s;
  opcls_t cls_b_s;

  assign cls_a_s = classify(bus.i_opa[W-1],
                            bus.i_opa[W-2 -: EXP_W],
                            bus.i_opa[MAN_W-1:0]);
  assign cls_b_s = classify(bus.i_opb[W-1] ^ bus.i_op_sub,
                            bus.i_opb[W-2 -: EXP_W],
                            bus.i_opb[MAN_W-1:0]);

  // Stage 1 register: take a new operand pair whenever the stage can move.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
    end else if (o_ready_s) begin
      s1_valid_r <= bus.i_valid;
      if (bus.i_valid) begin
        s1_a_r <= cls_a_s;
        s1_b_r <= cls_b_s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: bypass decision in priority order
  // ---------------------------------------------------------------------------
  logic         d_special_s;
  logic [1:0]   d_class_s;
  logic [W-1:0] d_result_s;
  logic         d_inv_s;

  // Resolve NaN, Inf - Inf, single Inf and (optionally) zero +/- zero.
  always_comb begin
    d_special_s = 1'b0;
    d_class_s   = CLS_NORMAL;
    d_result_s  = {W{1'b0}};
    d_inv_s     = 1'b0;
    if (s1_a_r.nan | s1_b_r.nan) begin
      // Any NaN propagates as the canonical qNaN; signalling NaN raises invalid.
      d_special_s = 1'b1;
      d_class_s   = CLS_QNAN;
      d_result_s  = QNAN_VAL;
      d_inv_s     = s1_a_r.snan | s1_b_r.snan;
    end else if (s1_a_r.inf & s1_b_r.inf & (s1_a_r.sign ^ s1_b_r.sign)) begin
      // Effective Inf - Inf has no defined value.
      d_special_s = 1'b1;
      d_class_s   = CLS_QNAN;
      d_result_s  = QNAN_VAL;
      d_inv_s     = 1'b1;
    end else if (s1_a_r.inf) begin
      d_special_s = 1'b1;
      d_class_s   = s1_a_r.sign ? CLS_NEG : CLS_PINF;
      d_result_s  = inf_val(s1_a_r.sign);
      d_inv_s     = 1'b0;
    end else if (s1_b_r.inf) begin
      d_special_s = 1'b1;
      d_class_s   = s1_b_r.sign ? CLS_NEG : CLS_PINF;
      d_result_s  = inf_val(s1_b_r.sign);
      d_inv_s     = 1'b0;
`ifdef FP_PSC_FTZ_EN
    end else if (s1_a_r.zero & s1_b_r.zero) begin
      // Round-to-nearest: the sum of two zeros is -0 only when both are -0.
      d_special_s = 1'b1;
      d_class_s   = CLS_NEG;
      d_result_s  = zero_val(s1_a_r.sign & s1_b_r.sign);
      d_inv_s     = 1'b0;
`endif
    end else begin
      d_special_s = 1'b0;
      d_class_s   = CLS_NORMAL;
      d_result_s  = {W{1'b0}};
      d_inv_s     = 1'b0;
    end
  end

  // Stage 2 register: load the decision when the output slot frees up, else hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_r   <= 1'b0;
      o_special_r <= 1'b0;
      o_class_r   <= CLS_NORMAL;
      o_result_r  <= {W{1'b0}};
      s2_inv_r    <= 1'b0;
    end else if (s2_adv_s) begin
      o_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        o_special_r <= d_special_s;
        o_class_r   <= d_class_s;
        o_result_r  <= d_result_s;
        s2_inv_r    <= d_inv_s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status: sticky invalid flag and saturating bypass counter
  // ---------------------------------------------------------------------------

  // Sticky invalid flag; a new invalid result wins over a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_flag_inv_r <= 1'b0;
    end else if (out_fire_s & s2_inv_r) begin
      o_flag_inv_r <= 1'b1;
    end else if (bus.i_flag_clr) begin
      o_flag_inv_r <= 1'b0;
    end
  end

  // Bypass counter; a clear coinciding with a bypass leaves a count of one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bypass_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.i_flag_clr) begin
      o_bypass_cnt_r <= byp_fire_s ? CNT_ONE : {CNT_W{1'b0}};
    end else if (byp_fire_s && (o_bypass_cnt_r != CNT_MAX)) begin
      o_bypass_cnt_r <= o_bypass_cnt_r + CNT_ONE;
    end
  end

  assign bus.o_ready      = o_ready_s;
  assign bus.o_valid      = o_valid_r;
  assign bus.o_special    = o_special_r;
  assign bus.o_class      = o_class_r;
  assign bus.o_result     = o_result_r;
  assign bus.o_flag_inv   = o_flag_inv_r;
  assign bus.o_bypass_cnt = o_bypass_cnt_r;

endmodule

// File: tb/tb_fp_special_case_pipe.sv
// Testbench for fp_special_case_pipe (single precision, 4-bit counter so that
// saturation is reachable). Directed table vectors, hand-written handshake,
// clear and reset sequences, and random operands checked against a
// behavioural model of the IEEE-754 special-case rules. A scoreboard queue
// holds the expected result of every accepted operand pair; a monitor pops it
// on every accepted output and tracks the expected flag and counter.
module tb_fp_special_case_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fp_special_case_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) bif ();

  fp_special_case_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        special;
    logic [1:0]  cls;
    logic [31:0] res;
    logic        inv;
  } vec_t;

  vec_t             exp_q[$];
  vec_t             tbl[12];
  int               checks = 0;
  int               failures = 0;
  logic             exp_flag;
  logic [CNT_W-1:0] exp_cnt;
  logic             rand_done;
  logic [31:0]      held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                              input logic sp, input logic [1:0] cls, input logic [31:0] res,
                              input logic inv);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.special = sp; v.cls = cls; v.res = res; v.inv = inv;
    return v;
  endfunction

  // Behavioural reference: IEEE-754 add/sub special cases, single precision.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    vec_t r;
    logic [7:0] ea, eb;
    logic nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, sa, sbe;
    ea = a[30:23]; eb = b[30:23];
    nan_a  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    nan_b  = (eb == 8'hFF) && (b[22:0] != 23'd0);
    snan_a = nan_a && !a[22];
    snan_b = nan_b && !b[22];
    inf_a  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    inf_b  = (eb == 8'hFF) && (b[22:0] == 23'd0);
`ifdef FP_PSC_FTZ_EN
    zero_a = (ea == 8'h00);
    zero_b = (eb == 8'h00);
`else
    zero_a = 1'b0;
    zero_b = 1'b0;
`endif
    sa  = a[31];
    sbe = b[31] ^ sub;
    r = mk(a, b, sub, 1'b1, 2'd0, 32'h0, 1'b0);
    if (nan_a || nan_b) begin
      r.cls = 2'd1; r.res = 32'h7FC00000; r.inv = snan_a || snan_b;
    end else if (inf_a && inf_b && (sa != sbe)) begin
      r.cls = 2'd1; r.res = 32'h7FC00000; r.inv = 1'b1;
    end else if (inf_a) begin
      r.cls = sa ? 2'd3 : 2'd2; r.res = sa ? 32'hFF800000 : 32'h7F800000;
    end else if (inf_b) begin
      r.cls = sbe ? 2'd3 : 2'd2; r.res = sbe ? 32'hFF800000 : 32'h7F800000;
    end else if (zero_a && zero_b) begin
      r.cls = 2'd3; r.res = (sa && sbe) ? 32'h80000000 : 32'h00000000;
    end else begin
      r.special = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic       s;
    logic [7:0] e;
    logic [22:0] m;
    s = 1'($urandom);
    e = 8'($urandom);
    m = 23'($urandom);
    case ($urandom_range(0, 5))
      0: begin e = 8'hFF; if (m == 23'd0) m = 23'd1; end
      1: begin e = 8'hFF; m = 23'd0; end
      2: begin e = 8'h00; m = 23'd0; end
      3: begin e = 8'h00; if (m == 23'd0) m = 23'd1; end
      default: ;
    endcase
    return {s, e, m};
  endfunction

  // Present one operand pair; called between a rising edge and the next falling edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input vec_t e);
    logic ok;
    bif.i_valid  = 1'b1;
    bif.i_opa    = a;
    bif.i_opb    = b;
    bif.i_op_sub = sub;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bif.o_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_ready required=ready");
    end
    @(posedge clk);
    #1;
    bif.i_valid = 1'b0;
  endtask

  task automatic drain();
    bif.i_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: check flag/counter every cycle, score every accepted output.
  initial begin : monitor
    logic fire, sp, inv;
    vec_t e;
    exp_flag = 1'b0;
    exp_cnt  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_flag = 1'b0;
        exp_cnt  = '0;
      end else begin
        chk("flag_inv", 64'(bif.o_flag_inv), 64'(exp_flag));
        chk("bypass_cnt", 64'(bif.o_bypass_cnt), 64'(exp_cnt));
        fire = bif.o_valid & bif.i_ready;
        sp = 1'b0;
        inv = 1'b0;
        if (fire) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0h required=none", bif.o_result);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("special a=%h b=%h sub=%0d", e.a, e.b, e.sub), 64'(bif.o_special), 64'(e.special));
            chk($sformatf("class a=%h b=%h sub=%0d", e.a, e.b, e.sub), 64'(bif.o_class), 64'(e.cls));
            chk($sformatf("result a=%h b=%h sub=%0d", e.a, e.b, e.sub), 64'(bif.o_result), 64'(e.res));
            sp  = e.special;
            inv = e.inv;
          end
        end
        if (fire && inv) exp_flag = 1'b1;
        else if (bif.i_flag_clr) exp_flag = 1'b0;
        if (bif.i_flag_clr) exp_cnt = (fire && sp) ? CNT_W'(1) : CNT_W'(0);
        else if (fire && sp && (exp_cnt != {CNT_W{1'b1}})) exp_cnt = exp_cnt + CNT_W'(1);
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] ra, rb;
    logic        rs;

    tbl[0]  = mk(32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 2'd1, 32'h7FC00000, 1'b1);
    tbl[1]  = mk(32'h7F800001, 32'h3F800000, 1'b0, 1'b1, 2'd1, 32'h7FC00000, 1'b1);
    tbl[2]  = mk(32'h3F800000, 32'hFF800000, 1'b1, 1'b1, 2'd2, 32'h7F800000, 1'b0);
    tbl[3]  = mk(32'h7FC00000, 32'h3F800000, 1'b0, 1'b1, 2'd1, 32'h7FC00000, 1'b0);
    tbl[4]  = mk(32'hFF800000, 32'h3F800000, 1'b0, 1'b1, 2'd3, 32'hFF800000, 1'b0);
    tbl[5]  = mk(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 2'd0, 32'h00000000, 1'b0);
    tbl[6]  = mk(32'h7F800000, 32'hFF800000, 1'b0, 1'b1, 2'd1, 32'h7FC00000, 1'b1);
    tbl[7]  = mk(32'hFF800000, 32'h7F800000, 1'b1, 1'b1, 2'd3, 32'hFF800000, 1'b0);
`ifdef FP_PSC_FTZ_EN
    tbl[8]  = mk(32'h80000001, 32'h00000000, 1'b1, 1'b1, 2'd3, 32'h80000000, 1'b0);
    tbl[9]  = mk(32'h00000000, 32'h80000000, 1'b0, 1'b1, 2'd3, 32'h00000000, 1'b0);
`else
    tbl[8]  = mk(32'h80000001, 32'h00000000, 1'b1, 1'b0, 2'd0, 32'h00000000, 1'b0);
    tbl[9]  = mk(32'h00000000, 32'h80000000, 1'b0, 1'b0, 2'd0, 32'h00000000, 1'b0);
`endif
    tbl[10] = mk(32'hFF800000, 32'h7F800001, 1'b0, 1'b1, 2'd1, 32'h7FC00000, 1'b1);
    tbl[11] = mk(32'h00400000, 32'h3F800000, 1'b0, 1'b0, 2'd0, 32'h00000000, 1'b0);

    bif.i_valid = 1'b0; bif.i_opa = 32'h0; bif.i_opb = 32'h0; bif.i_op_sub = 1'b0;
    bif.i_ready = 1'b1; bif.i_flag_clr = 1'b0;
    rand_done = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid",  64'(bif.o_valid), 64'd0);
    chk("rst_special",  64'(bif.o_special), 64'd0);
    chk("rst_class",    64'(bif.o_class), 64'd0);
    chk("rst_result",   64'(bif.o_result), 64'd0);
    chk("rst_flag",     64'(bif.o_flag_inv), 64'd0);
    chk("rst_cnt",      64'(bif.o_bypass_cnt), 64'd0);
    chk("rst_o_ready",  64'(bif.o_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-cycle latency on +Inf - +Inf.
    send(tbl[0].a, tbl[0].b, tbl[0].sub, tbl[0]);
    @(negedge clk);
    chk("latency_cycle1_valid", 64'(bif.o_valid), 64'd0);
    @(negedge clk);
    chk("latency_cycle2_valid", 64'(bif.o_valid), 64'd1);
    @(negedge clk);
    chk("latency_flag_inv", 64'(bif.o_flag_inv), 64'd1);
    chk("latency_cnt", 64'(bif.o_bypass_cnt), 64'd1);
    @(posedge clk); #1;

    // Table vectors, back to back.
    for (int i = 1; i < 12; i++) send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i]);
    drain();

    // Clear coinciding with an invalid bypass: set wins, counter restarts at 1.
    send(tbl[1].a, tbl[1].b, tbl[1].sub, tbl[1]);
    @(posedge clk); #1;
    bif.i_flag_clr = 1'b1;
    @(posedge clk); #1;
    bif.i_flag_clr = 1'b0;
    @(negedge clk);
    chk("clr_and_set_flag", 64'(bif.o_flag_inv), 64'd1);
    chk("clr_and_inc_cnt", 64'(bif.o_bypass_cnt), 64'd1);
    @(posedge clk); #1;

    // Plain clear.
    bif.i_flag_clr = 1'b1;
    @(posedge clk); #1;
    bif.i_flag_clr = 1'b0;
    @(negedge clk);
    chk("clr_flag", 64'(bif.o_flag_inv), 64'd0);
    chk("clr_cnt", 64'(bif.o_bypass_cnt), 64'd0);
    @(posedge clk); #1;

    // Four back-to-back ops with the output stalled for three cycles.
    fork
      begin
        send(tbl[2].a, tbl[2].b, tbl[2].sub, tbl[2]);
        send(tbl[4].a, tbl[4].b, tbl[4].sub, tbl[4]);
        send(tbl[5].a, tbl[5].b, tbl[5].sub, tbl[5]);
        send(tbl[7].a, tbl[7].b, tbl[7].sub, tbl[7]);
      end
      begin
        @(posedge clk);
        @(posedge clk); #1;
        bif.i_ready = 1'b0;
        held = bif.o_result;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_o_valid", 64'(bif.o_valid), 64'd1);
          chk("stall_o_ready", 64'(bif.o_ready), 64'd0);
          chk("stall_result_held", 64'(bif.o_result), 64'(tbl[2].res));
          @(posedge clk); #1;
        end
        bif.i_ready = 1'b1;
      end
    join
    drain();

    // Random operands with random backpressure and occasional clears.
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          ra = rand_op();
          rb = rand_op();
          rs = 1'($urandom);
          send(ra, rb, rs, model(ra, rb, rs));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bif.i_ready    = ($urandom_range(0, 3) != 0);
          bif.i_flag_clr = ($urandom_range(0, 15) == 0);
        end
      end
    join
    bif.i_flag_clr = 1'b0;
    drain();

    // Counter saturation.
    bif.i_flag_clr = 1'b1;
    @(posedge clk); #1;
    bif.i_flag_clr = 1'b0;
    for (int n = 0; n < 20; n++) send(tbl[4].a, tbl[4].b, tbl[4].sub, tbl[4]);
    drain();
    @(negedge clk);
    chk("cnt_saturated", 64'(bif.o_bypass_cnt), 64'hF);
    @(posedge clk); #1;

    // Reset with two operations in flight.
    send(tbl[0].a, tbl[0].b, tbl[0].sub, tbl[0]);
    send(tbl[2].a, tbl[2].b, tbl[2].sub, tbl[2]);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_o_valid", 64'(bif.o_valid), 64'd0);
    chk("midrst_flag", 64'(bif.o_flag_inv), 64'd0);
    chk("midrst_cnt", 64'(bif.o_bypass_cnt), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("postrst_o_valid", 64'(bif.o_valid), 64'd0);
      chk("postrst_flag", 64'(bif.o_flag_inv), 64'd0);
      chk("postrst_cnt", 64'(bif.o_bypass_cnt), 64'd0);
    end
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
